vec_addsub_sat_seq: RTL and testbench
=====================================

Name: vec_addsub_sat_seq

Overview:
- Parametrised successor to the fixed 3-element, 21-bit vector-add loop in the estimator datapath.
- Computes y[i] = sat(a[i] ± b[i]) for N signed W-bit elements, one element per cycle, through a single shared saturating adder.
- Adds a runtime add/sub mode and per-element saturation reporting.
- Sits between estimator matrix-vector stages with the ap_start/ap_done/ap_idle/ap_ready control handshake.

Parameters:
- W, 21, element width in bits, signed two's complement, W >= 2.
- N, 3, vector length, N >= 1.
- IW, $clog2(N) (min 1), element index counter width.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when results are valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse in the same cycle as ap_done; the block accepts ap_start from the next cycle.
- mode_sub  in  1  0: a+b; 1: a-b; latched at start.
- a_flat  in  N*W  operand vector; element i is bits [i*W +: W]; latched at start.
- b_flat  in  N*W  operand vector; same packing; latched at start.
- y_flat  out  N*W  result vector; same packing; registered.
- y_vld  out  1  equal to ap_done.
- sat_mask  out  N  bit i set if element i saturated on the last run.
- sat_any  out  1  OR of sat_mask; registered.

Behaviour:
- Reset (async, ap_rst_n=0):
  - FSM returns to IDLE; index counter cleared.
  - y_flat=0, sat_mask=0, sat_any=0, ap_done=ap_ready=y_vld=0, ap_idle=1.
  - Latched operands cleared.
  - Reset mid-run aborts the run; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ap_idle=1. When ap_start=1, latch a_flat, b_flat and mode_sub, set i=0, clear sat_mask, go to RUN.
  - RUN: each cycle, compute element i from the latched operands, write y[i] and sat_mask[i], then i++. When i==N-1, go to DONE.
  - DONE: ap_done=ap_ready=y_vld=1 for exactly this cycle; sat_any updates; next state is IDLE.
- Latency: start accepted in cycle 0; RUN covers cycles 1..N; done pulses in cycle N+1.
- Minimum start-to-start spacing is N+2 cycles.
- ap_start is ignored in RUN and DONE; it is not queued.
- Input changes after the start cycle have no effect on the current run.
- Arithmetic:
  - Sign-extend both operands to W+1 bits; form s = a + b, or s = a - b when mode_sub=1.
  - Overflow is detected when s[W] != s[W-1].
  - On overflow, y = s[W] ? MIN : MAX, with MAX = 2^(W-1)-1 and MIN = -2^(W-1); the sat bit is set.
  - Otherwise y = s[W-1:0].
- Subtraction of MIN (b = MIN) must use the W+1-bit negate so it saturates correctly, never wraps.
- y_flat elements not yet rewritten during a run keep their previous-run values. y_flat is defined only at ap_done; consumers sample it there.
- No combinational path from inputs to any output.

Decomposition:
- Shared package vec_pkg:
  - FSM state enum {IDLE, RUN, DONE}.
  - Functions sat_max(W) and sat_min(W).
  - Element slice helper for the flat packing.
- Sub-module sat_addsub_elem (parameter W):
  - Purely combinational; ports a, b, sub -> y, sat.
  - Instantiated once and time-multiplexed by the index counter.
  - Reusable by later matrix-vector blocks.

Test Plan:
- W=21, N=3, add: a={5,-7,1000}, b={3,2,-1000} -> y={8,-5,0}, sat_mask=000, ap_done pulses in cycle 4 after start.
- Positive overflow: a0=1048575, b0=1 (add) -> y0=1048575, sat_mask[0]=1, sat_any=1; other elements exact.
- Negative and subtract edge: a1=-1048576, b1=1, mode_sub=1 -> y1=-1048576, sat. Then a2=0, b2=-1048576, mode_sub=1 -> y2=1048575, sat.
- Operand change mid-run and ap_start held high throughout:
  - Results match the values latched at start.
  - Second run begins only from IDLE; done pulses exactly N+2 cycles apart.
- ap_rst_n asserted in RUN cycle 2:
  - Outputs clear immediately (async); no ap_done pulse; ap_idle=1.
  - A subsequent run completes normally.
- Sweep N=1 and N=8, W=8, with random vectors vs. a reference model: every element and sat bit matches; done latency = N+1.

Source files
------------

// File: rtl/vec_addsub_sat_seq_pkg.sv
// Shared definitions for the vector add/sub saturation datapath:
// FSM state encoding, saturation bound helpers and flat-vector slicing.
package vec_pkg;

  // Control FSM states for the sequential vector engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest positive value of a w-bit signed number, right-aligned in 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed number; the low w bits read 100..0.
  function automatic logic [63:0] sat_min(input int w);
    sat_min = ~sat_max(w);
  endfunction

  // Lowest bit position of element idx in a flat vector of w-bit elements.
  function automatic int elem_lo(input int idx, input int w);
    elem_lo = idx * w;
  endfunction

endpackage

// File: rtl/vec_addsub_sat_seq_elem.sv
// Single-element saturating adder/subtractor. Purely combinational so one
// instance can be time-multiplexed across vector elements.
module sat_addsub_elem #(
  parameter int W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         sat
);
  import vec_pkg::*;

  localparam logic [63:0]  MAX_64 = sat_max(W);
  localparam logic [63:0]  MIN_64 = sat_min(W);
  localparam logic [W-1:0] MAX_C  = MAX_64[W-1:0];
  localparam logic [W-1:0] MIN_C  = MIN_64[W-1:0];

  logic [W:0] a_ext_s;
  logic [W:0] b_ext_s;
  logic [W:0] sum_s;

  // Widen by one bit so a - MIN is formed exactly and can be clamped.
  always_comb begin
    a_ext_s = {a[W-1], a};
    b_ext_s = {b[W-1], b};
    if (sub) begin
      sum_s = a_ext_s - b_ext_s;
    end else begin
      sum_s = a_ext_s + b_ext_s;
    end
    sat = sum_s[W] ^ sum_s[W-1];
    if (sat) begin
      if (sum_s[W]) begin
        y = MIN_C;
      end else begin
        y = MAX_C;
      end
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/vec_addsub_sat_seq.sv
// Sequential N-element saturating vector add/sub with ap_* handshake.
// Operands are latched at start; one element per cycle goes through a shared
// saturating adder; results and per-element saturation flags are registered.
module vec_addsub_sat_seq #(
  parameter int W  = 21,
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ap_start,
  output logic           ap_done,
  output logic           ap_idle,
  output logic           ap_ready,
  input  logic           mode_sub,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N*W-1:0] y_flat,
  output logic           y_vld,
  output logic [N-1:0]   sat_mask,
  output logic           sat_any
);
  import vec_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e         state_r;
  logic [IW-1:0]  idx_r;
  logic [N*W-1:0] a_lat_r;
  logic [N*W-1:0] b_lat_r;
  logic           sub_lat_r;
  logic [N*W-1:0] y_r;
  logic [N-1:0]   mask_r;
  logic           any_r;
  logic           done_r;
  logic           idle_r;

  logic [W-1:0]   a_sel_s;
  logic [W-1:0]   b_sel_s;
  logic [W-1:0]   y_elem_s;
  logic           sat_elem_s;
  logic [N*W-1:0] y_next_s;
  logic [N-1:0]   mask_next_s;

  // Pick the current element of the latched operands.
  always_comb begin
    a_sel_s = {W{1'b0}};
    b_sel_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      a_sel_s = (idx_r == IW'(k)) ? a_lat_r[elem_lo(k, W) +: W] : a_sel_s;
      b_sel_s = (idx_r == IW'(k)) ? b_lat_r[elem_lo(k, W) +: W] : b_sel_s;
    end
  end

  sat_addsub_elem #(
    .W (W)
  ) u_elem (
    .a   (a_sel_s),
    .b   (b_sel_s),
    .sub (sub_lat_r),
    .y   (y_elem_s),
    .sat (sat_elem_s)
  );

  // Merge the fresh element into the result vector and saturation mask.
  always_comb begin
    y_next_s    = y_r;
    mask_next_s = mask_r;
    for (int k = 0; k < N; k++) begin
      y_next_s[elem_lo(k, W) +: W] = (idx_r == IW'(k)) ? y_elem_s : y_r[elem_lo(k, W) +: W];
      mask_next_s[k]               = (idx_r == IW'(k)) ? sat_elem_s : mask_r[k];
    end
  end

  // Control FSM with operand latches and all registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r   <= IDLE;
      idx_r     <= {IW{1'b0}};
      a_lat_r   <= {(N*W){1'b0}};
      b_lat_r   <= {(N*W){1'b0}};
      sub_lat_r <= 1'b0;
      y_r       <= {(N*W){1'b0}};
      mask_r    <= {N{1'b0}};
      any_r     <= 1'b0;
      done_r    <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (ap_start) begin
            a_lat_r   <= a_flat;
            b_lat_r   <= b_flat;
            sub_lat_r <= mode_sub;
            idx_r     <= {IW{1'b0}};
            mask_r    <= {N{1'b0}};
            idle_r    <= 1'b0;
            state_r   <= RUN;
          end else begin
            idle_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        RUN: begin
          y_r    <= y_next_s;
          mask_r <= mask_next_s;
          if (idx_r == LAST_IDX) begin
            any_r   <= |mask_next_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IW'(1);
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          idle_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          idle_r  <= 1'b1;
          idx_r   <= {IW{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ap_done  = done_r;
  assign ap_ready = done_r;
  assign y_vld    = done_r;
  assign ap_idle  = idle_r;
  assign y_flat   = y_r;
  assign sat_mask = mask_r;
  assign sat_any  = any_r;

endmodule

// File: tb/tb_vec_addsub_sat_seq.sv
// Bench for vec_addsub_sat_seq: main W=21/N=3 instance checked every cycle
// against a timeline model, plus W=8 instances with N=1 and N=8.
module tb_vec_addsub_sat_seq;
  localparam int MW = 21;
  localparam int MN = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main DUT
  logic             ap_start, ap_done, ap_idle, ap_ready, mode_sub, y_vld, sat_any;
  logic [MN*MW-1:0] a_flat, b_flat, y_flat;
  logic [MN-1:0]    sat_mask;

  vec_addsub_sat_seq #(.W(MW), .N(MN)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .mode_sub(mode_sub),
    .a_flat(a_flat), .b_flat(b_flat), .y_flat(y_flat), .y_vld(y_vld),
    .sat_mask(sat_mask), .sat_any(sat_any));

  // W=8, N=8 instance
  logic        s8_start, s8_done, s8_idle, s8_ready, s8_sub, s8_vld, s8_any;
  logic [63:0] s8_a, s8_b, s8_y;
  logic [7:0]  s8_mask;

  vec_addsub_sat_seq #(.W(8), .N(8)) dut8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(s8_start), .ap_done(s8_done),
    .ap_idle(s8_idle), .ap_ready(s8_ready), .mode_sub(s8_sub),
    .a_flat(s8_a), .b_flat(s8_b), .y_flat(s8_y), .y_vld(s8_vld),
    .sat_mask(s8_mask), .sat_any(s8_any));

  // W=8, N=1 instance
  logic       s1_start, s1_done, s1_idle, s1_ready, s1_sub, s1_vld, s1_any;
  logic [7:0] s1_a, s1_b, s1_y;
  logic [0:0] s1_mask;

  vec_addsub_sat_seq #(.W(8), .N(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(s1_start), .ap_done(s1_done),
    .ap_idle(s1_idle), .ap_ready(s1_ready), .mode_sub(s1_sub),
    .a_flat(s1_a), .b_flat(s1_b), .y_flat(s1_y), .y_vld(s1_vld),
    .sat_mask(s1_mask), .sat_any(s1_any));

  // model helpers: plain integer arithmetic with clamping
  function automatic longint sext(input longint raw, input int w);
    longint v;
    v = raw & ((longint'(1) << w) - 1);
    if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic void ref_elem(input longint a, input longint b, input bit sub,
                                   input int w, output longint y, output bit s);
    longint r, mx, mn;
    r  = sub ? (a - b) : (a + b);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    if (r > mx) begin y = mx; s = 1'b1; end
    else if (r < mn) begin y = mn; s = 1'b1; end
    else begin y = r; s = 1'b0; end
  endfunction

  function automatic longint yel(input int i);
    return sext(longint'(y_flat[i*MW +: MW]), MW);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // main-DUT model state
  int     cyc = 0;
  int     done_at = -1;
  int     free_at = 0;
  longint exp_y [MN];
  bit     exp_m [MN];
  int     done_log[$];

  task automatic run_main(input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2,
                          input bit sb, output int lat);
    lat      = -1;
    a_flat   = {MW'(a2), MW'(a1), MW'(a0)};
    b_flat   = {MW'(b2), MW'(b1), MW'(b0)};
    mode_sub = sb;
    ap_start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ap_done) begin lat = c; break; end
      @(posedge clk); #1 ap_start = 1'b0;
    end
    ap_start = 1'b0;
  endtask

  task automatic run8(input logic [63:0] av, input logic [63:0] bv, input bit sb);
    int     lat;
    longint ey;
    bit     es, eany;
    lat = -1; eany = 1'b0;
    s8_a = av; s8_b = bv; s8_sub = sb; s8_start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s8_done) begin lat = c; break; end
      @(posedge clk); #1 s8_start = 1'b0;
    end
    s8_start = 1'b0;
    chk("n8_latency", lat, 9);
    for (int i = 0; i < 8; i++) begin
      ref_elem(sext(longint'(av[i*8 +: 8]), 8), sext(longint'(bv[i*8 +: 8]), 8), sb, 8, ey, es);
      chk($sformatf("n8_y%0d", i), sext(longint'(s8_y[i*8 +: 8]), 8), ey);
      chk($sformatf("n8_sat%0d", i), longint'(s8_mask[i]), longint'(es));
      eany = eany | es;
    end
    chk("n8_any", longint'(s8_any), longint'(eany));
    @(posedge clk); #1;
  endtask

  task automatic run1(input logic [7:0] av, input logic [7:0] bv, input bit sb);
    int     lat;
    longint ey;
    bit     es;
    lat = -1;
    s1_a = av; s1_b = bv; s1_sub = sb; s1_start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s1_done) begin lat = c; break; end
      @(posedge clk); #1 s1_start = 1'b0;
    end
    s1_start = 1'b0;
    chk("n1_latency", lat, 2);
    ref_elem(sext(longint'(av), 8), sext(longint'(bv), 8), sb, 8, ey, es);
    chk("n1_y", sext(longint'(s1_y), 8), ey);
    chk("n1_sat", longint'(s1_mask[0]), longint'(es));
    chk("n1_any", longint'(s1_any), longint'(es));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    ap_start = 1'b0; mode_sub = 1'b0; a_flat = '0; b_flat = '0;
    s8_start = 1'b0; s8_sub = 1'b0; s8_a = '0; s8_b = '0;
    s1_start = 1'b0; s1_sub = 1'b0; s1_a = '0; s1_b = '0;
    #1 rst_n = 1'b0;
    fork
      // per-cycle compare of the main DUT against the timeline model
      forever begin
        bit     e_done, e_idle;
        longint ey;
        bit     es, eany;
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_idle", longint'(ap_idle), 1);
          chk("rst_done", longint'(ap_done), 0);
          chk("rst_ready", longint'(ap_ready), 0);
          chk("rst_vld", longint'(y_vld), 0);
          chk("rst_mask", longint'(sat_mask), 0);
          chk("rst_any", longint'(sat_any), 0);
          for (int i = 0; i < MN; i++) chk("rst_y", yel(i), 0);
          done_at = -1;
          free_at = cyc + 1;
        end else begin
          e_done = (cyc == done_at);
          e_idle = (cyc >= free_at);
          chk("done", longint'(ap_done), longint'(e_done));
          chk("ready", longint'(ap_ready), longint'(e_done));
          chk("vld", longint'(y_vld), longint'(e_done));
          chk("idle", longint'(ap_idle), longint'(e_idle));
          if (e_done) begin
            eany = 1'b0;
            for (int i = 0; i < MN; i++) begin
              chk($sformatf("y%0d", i), yel(i), exp_y[i]);
              chk($sformatf("sat%0d", i), longint'(sat_mask[i]), longint'(exp_m[i]));
              eany = eany | exp_m[i];
            end
            chk("sat_any", longint'(sat_any), longint'(eany));
          end
          if (ap_done) done_log.push_back(cyc);
          if (e_idle && ap_start) begin
            for (int i = 0; i < MN; i++) begin
              ref_elem(sext(longint'(a_flat[i*MW +: MW]), MW),
                       sext(longint'(b_flat[i*MW +: MW]), MW), mode_sub, MW, ey, es);
              exp_y[i] = ey;
              exp_m[i] = es;
            end
            done_at = cyc + MN + 1;
            free_at = cyc + MN + 2;
          end
        end
        cyc++;
      end
      // directed stimulus
      begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic add
        run_main(5, -7, 1000, 3, 2, -1000, 1'b0, lat);
        chk("add_latency", lat, 4);
        chk("add_y0", yel(0), 8);
        chk("add_y1", yel(1), -5);
        chk("add_y2", yel(2), 0);
        chk("add_mask", longint'(sat_mask), 0);
        @(posedge clk); #1;

        // positive overflow on element 0
        run_main(1048575, 10, -3, 1, 20, -4, 1'b0, lat);
        chk("povf_latency", lat, 4);
        chk("povf_y0", yel(0), 1048575);
        chk("povf_y1", yel(1), 30);
        chk("povf_y2", yel(2), -7);
        chk("povf_mask", longint'(sat_mask), 1);
        chk("povf_any", longint'(sat_any), 1);
        @(posedge clk); #1;

        // subtract edges: MIN-1 and 0-MIN
        run_main(100, -1048576, 0, 58, 1, -1048576, 1'b1, lat);
        chk("sub_y0", yel(0), 42);
        chk("sub_y1", yel(1), -1048576);
        chk("sub_y2", yel(2), 1048575);
        chk("sub_mask", longint'(sat_mask), 6);
        @(posedge clk); #1;

        // start held high with operands changing every cycle
        done_log.delete();
        a_flat = {MW'(-9), MW'(400), MW'(1048000)};
        b_flat = {MW'(9), MW'(-401), MW'(1000)};
        mode_sub = 1'b0;
        ap_start = 1'b1;
        for (int k = 0; k < 14; k++) begin
          @(posedge clk); #1;
          a_flat   = 63'({$urandom, $urandom});
          b_flat   = 63'({$urandom, $urandom});
          mode_sub = 1'($urandom_range(0, 1));
        end
        ap_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("held_done_count", done_log.size(), 3);
        if (done_log.size() >= 3) begin
          chk("held_spacing_a", done_log[1] - done_log[0], MN + 2);
          chk("held_spacing_b", done_log[2] - done_log[1], MN + 2);
        end

        // reset asserted in RUN cycle 2
        done_log.delete();
        a_flat = {MW'(1), MW'(2), MW'(3)};
        b_flat = {MW'(4), MW'(5), MW'(6)};
        mode_sub = 1'b0;
        ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_idle", longint'(ap_idle), 1);
        chk("midrst_done", longint'(ap_done), 0);
        chk("midrst_y0", yel(0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", done_log.size(), 0);
        run_main(-20, 7, 300, -30, 7, 1, 1'b1, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_y0", yel(0), 10);
        chk("post_rst_y1", yel(1), 0);
        chk("post_rst_y2", yel(2), 299);
        @(posedge clk); #1;

        // N=8, W=8: edge vectors then random ones
        run8(64'h807F_0180_7F80_0102, 64'h0101_FF80_7F01_FFFE, 1'b0);
        run8(64'h807F_0180_7F00_0102, 64'h0101_FF80_8080_FFFE, 1'b1);
        for (int r = 0; r < 5; r++) run8({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // N=1, W=8
        run1(8'h7F, 8'h01, 1'b0);
        run1(8'h00, 8'h80, 1'b1);
        run1(8'h80, 8'h01, 1'b1);
        run1(8'h12, 8'h34, 1'b0);
        for (int r = 0; r < 4; r++) run1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
